// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Brief    : RV32I main decoder sequenced by a FETCH/DECODE/EXEC/MEM/WB FSM,
//            with memory-handshake timeout and retired-instruction counter.
//            Optional ILLEGAL_TRAP_EN: unknown opcodes trap instead of NOP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
    parameter int WAIT_LIMIT = 15,
    parameter int RET_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic             i_imemReady,
    input  logic             i_memReady,
    output logic             o_imemReq,
    output logic             o_irWrite,
    output logic             o_pcWrite,
    output logic             o_memReq,
    output logic             o_memWrite,
    output logic             o_regWrite,
    output logic             o_ALUSrc,
    output logic [2:0]       o_immSrc,
    output logic             o_immPlusSrc,
    output logic             o_isLoadSigned,
    output logic [1:0]       o_resultSrc,
    output logic             o_branch,
    output logic             o_jal,
    output logic             o_jalr,
    output logic [1:0]       o_ALUOp,
    output logic [2:0]       o_state,
    output logic             o_busError,
    output logic [RET_W-1:0] o_retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam int            c_CW     = $clog2(WAIT_LIMIT + 2);
    localparam logic [c_CW-1:0] c_LIM_M1 = c_CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    logic [2:0]       r_state;
    logic [2:0]       w_stateNext;
    logic [c_CW-1:0]  r_waitCnt;
    logic             r_busError;
    logic [RET_W-1:0] r_retired;

    logic [1:0] r_ALUOp,     w_ALUOp;
    logic       r_ALUSrc,    w_ALUSrc;
    logic [2:0] r_immSrc,    w_immSrc;
    logic       r_immPlus,   w_immPlus;
    logic       r_ldSigned,  w_ldSigned;
    logic [1:0] r_resultSrc, w_resultSrc;
    logic       r_branch,    w_branch;
    logic       r_jal,       w_jal;
    logic       r_jalr,      w_jalr;
    logic       r_isLoad,    w_isLoad;
    logic       r_isStore,   w_isStore;
    logic       r_isNop,     w_known;

    logic w_waiting;
    logic w_timeout;
    logic w_unused_f3;

    assign w_unused_f3 = ^i_funct3[1:0];

    always_comb begin
        w_ALUOp     = 2'b00;
        w_ALUSrc    = 1'b0;
        w_immSrc    = 3'b000;
        w_immPlus   = 1'b0;
        w_ldSigned  = 1'b0;
        w_resultSrc = 2'b00;
        w_branch    = 1'b0;
        w_jal       = 1'b0;
        w_jalr      = 1'b0;
        w_isLoad    = 1'b0;
        w_isStore   = 1'b0;
        w_known     = 1'b1;
        case (i_opcode)
            7'b0000011: begin
                w_ALUSrc = 1'b1; w_resultSrc = 2'b01;
                w_ldSigned = ~i_funct3[2]; w_isLoad = 1'b1;
            end
            7'b0100011: begin
                w_ALUSrc = 1'b1; w_immSrc = 3'b001; w_isStore = 1'b1;
            end
            7'b0110011: w_ALUOp = 2'b10;
            7'b0010011: begin
                w_ALUOp = 2'b10; w_ALUSrc = 1'b1;
            end
            7'b1100011: begin
                w_ALUOp = 2'b01; w_immSrc = 3'b010; w_branch = 1'b1;
            end
            7'b1101111: begin
                w_immSrc = 3'b100; w_resultSrc = 2'b10; w_jal = 1'b1;
            end
            7'b1100111: begin
                w_ALUSrc = 1'b1; w_resultSrc = 2'b10; w_jalr = 1'b1;
            end
            7'b0110111: begin
                w_immSrc = 3'b011; w_resultSrc = 2'b11;
            end
            7'b0010111: begin
                w_immSrc = 3'b011; w_resultSrc = 2'b11; w_immPlus = 1'b1;
            end
            default: w_known = 1'b0;
        endcase
    end

    // A ready in the limit cycle means this is not a wait cycle, so it wins.
    assign w_waiting = ((r_state == S_FETCH) && !i_imemReady) ||
                       ((r_state == S_MEM)   && !i_memReady);
    assign w_timeout = (WAIT_LIMIT > 0) && w_waiting && (r_waitCnt == c_LIM_M1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_timeout)        w_stateNext = S_ERROR;
                else if (i_imemReady) w_stateNext = S_DECODE;
            end
`ifdef ILLEGAL_TRAP_EN
            S_DECODE: w_stateNext = w_known ? S_EXEC : S_TRAP;
            S_TRAP:   w_stateNext = S_TRAP;
`else
            S_DECODE: w_stateNext = S_EXEC;
`endif
            S_EXEC: begin
                if (r_branch || r_isNop)        w_stateNext = S_FETCH;
                else if (r_isLoad || r_isStore) w_stateNext = S_MEM;
                else                            w_stateNext = S_WB;
            end
            S_MEM: begin
                if (w_timeout)       w_stateNext = S_ERROR;
                else if (i_memReady) w_stateNext = r_isStore ? S_FETCH : S_WB;
            end
            S_WB:    w_stateNext = S_FETCH;
            S_ERROR: w_stateNext = S_ERROR;
            default: w_stateNext = S_FETCH;
        endcase
    end

    always_comb begin
        o_imemReq  = (r_state == S_FETCH);
        o_irWrite  = (r_state == S_FETCH) && i_imemReady;
        o_memReq   = (r_state == S_MEM);
        o_memWrite = (r_state == S_MEM) && r_isStore;
        o_regWrite = (r_state == S_WB);
        o_pcWrite  = (r_state == S_WB) ||
                     ((r_state == S_EXEC) && (r_branch || r_isNop)) ||
                     ((r_state == S_MEM) && r_isStore && i_memReady);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_waitCnt  <= '0;
            r_busError <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_waitCnt <= (w_waiting && (w_stateNext == r_state)) ? r_waitCnt + 1'b1 : '0;
            if (w_timeout) r_busError <= 1'b1;
            if (o_pcWrite) r_retired  <= r_retired + RET_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ALUOp <= '0; r_ALUSrc <= 1'b0; r_immSrc <= '0; r_immPlus <= 1'b0;
            r_ldSigned <= 1'b0; r_resultSrc <= '0; r_branch <= 1'b0;
            r_jal <= 1'b0; r_jalr <= 1'b0; r_isLoad <= 1'b0;
            r_isStore <= 1'b0; r_isNop <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_ALUOp <= w_ALUOp; r_ALUSrc <= w_ALUSrc; r_immSrc <= w_immSrc;
            r_immPlus <= w_immPlus; r_ldSigned <= w_ldSigned;
            r_resultSrc <= w_resultSrc; r_branch <= w_branch; r_jal <= w_jal;
            r_jalr <= w_jalr; r_isLoad <= w_isLoad; r_isStore <= w_isStore;
            r_isNop <= ~w_known;
        end
    end

    assign o_ALUOp        = r_ALUOp;
    assign o_ALUSrc       = r_ALUSrc;
    assign o_immSrc       = r_immSrc;
    assign o_immPlusSrc   = r_immPlus;
    assign o_isLoadSigned = r_ldSigned;
    assign o_resultSrc    = r_resultSrc;
    assign o_branch       = r_branch;
    assign o_jal          = r_jal;
    assign o_jalr         = r_jalr;
    assign o_state        = r_state;
    assign o_busError     = r_busError;
    assign o_retired      = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Randomized self-checking bench for multicycle_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    localparam int WAIT_LIMIT = 15;
    localparam int RET_W      = 32;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic [6:0]       i_opcode;
    logic [2:0]       i_funct3;
    logic             i_imemReady, i_memReady;
    logic             o_imemReq, o_irWrite, o_pcWrite, o_memReq, o_memWrite, o_regWrite;
    logic             o_ALUSrc, o_immPlusSrc, o_isLoadSigned, o_branch, o_jal, o_jalr;
    logic [2:0]       o_immSrc, o_state;
    logic [1:0]       o_resultSrc, o_ALUOp;
    logic             o_busError;
    logic [RET_W-1:0] o_retired;

    multicycle_controller #(.WAIT_LIMIT(WAIT_LIMIT), .RET_W(RET_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_funct3(i_funct3),
        .i_imemReady(i_imemReady), .i_memReady(i_memReady),
        .o_imemReq(o_imemReq), .o_irWrite(o_irWrite), .o_pcWrite(o_pcWrite),
        .o_memReq(o_memReq), .o_memWrite(o_memWrite), .o_regWrite(o_regWrite),
        .o_ALUSrc(o_ALUSrc), .o_immSrc(o_immSrc), .o_immPlusSrc(o_immPlusSrc),
        .o_isLoadSigned(o_isLoadSigned), .o_resultSrc(o_resultSrc),
        .o_branch(o_branch), .o_jal(o_jal), .o_jalr(o_jalr), .o_ALUOp(o_ALUOp),
        .o_state(o_state), .o_busError(o_busError), .o_retired(o_retired)
    );

    always #5 i_clk = ~i_clk;

    int          total = 0;
    int          bad   = 0;
    logic [12:0] exp_ctl;
    logic [31:0] exp_ret;
    logic        exp_be;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // {ALUOp, ALUSrc, immSrc, immPlusSrc, isLoadSigned, resultSrc, branch, jal, jalr}
    function automatic logic [12:0] ref_ctl(input logic [6:0] opc, input logic [2:0] f3);
        case (opc)
            7'b0000011: return {2'b00, 1'b1, 3'b000, 1'b0, ~f3[2], 2'b01, 3'b000};
            7'b0100011: return {2'b00, 1'b1, 3'b001, 1'b0, 1'b0,   2'b00, 3'b000};
            7'b0110011: return {2'b10, 1'b0, 3'b000, 1'b0, 1'b0,   2'b00, 3'b000};
            7'b0010011: return {2'b10, 1'b1, 3'b000, 1'b0, 1'b0,   2'b00, 3'b000};
            7'b1100011: return {2'b01, 1'b0, 3'b010, 1'b0, 1'b0,   2'b00, 3'b100};
            7'b1101111: return {2'b00, 1'b0, 3'b100, 1'b0, 1'b0,   2'b10, 3'b010};
            7'b1100111: return {2'b00, 1'b1, 3'b000, 1'b0, 1'b0,   2'b10, 3'b001};
            7'b0110111: return {2'b00, 1'b0, 3'b011, 1'b0, 1'b0,   2'b11, 3'b000};
            7'b0010111: return {2'b00, 1'b0, 3'b011, 1'b1, 1'b0,   2'b11, 3'b000};
            default:    return 13'd0;
        endcase
    endfunction

    function automatic logic is_known(input logic [6:0] opc);
        return (opc == 7'b0000011) || (opc == 7'b0100011) || (opc == 7'b0110011) ||
               (opc == 7'b0010011) || (opc == 7'b1100011) || (opc == 7'b1101111) ||
               (opc == 7'b1100111) || (opc == 7'b0110111) || (opc == 7'b0010111);
    endfunction

    // fl = {imemReq, irWrite, memReq, memWrite, regWrite, pcWrite}
    task automatic run_cycle(input logic imr, input logic mr, input logic [6:0] opc,
                             input logic [2:0] f3, input logic [2:0] st, input logic [5:0] fl);
        i_imemReady = imr; i_memReady = mr; i_opcode = opc; i_funct3 = f3;
        @(negedge i_clk);
        check("state", 64'(o_state), 64'(st));
        check("flags", 64'({o_imemReq, o_irWrite, o_memReq, o_memWrite, o_regWrite, o_pcWrite}), 64'(fl));
        check("ctl", 64'({o_ALUOp, o_ALUSrc, o_immSrc, o_immPlusSrc, o_isLoadSigned,
                          o_resultSrc, o_branch, o_jal, o_jalr}), 64'(exp_ctl));
        check("retired", 64'(o_retired), 64'(exp_ret));
        check("busError", 64'(o_busError), 64'(exp_be));
        if (fl[0]) exp_ret++;
        @(posedge i_clk); #1;
    endtask

    task automatic rnd_cycle(input logic imr, input logic mr, input logic [2:0] st, input logic [5:0] fl);
        run_cycle(imr, mr, 7'($urandom), 3'($urandom), st, fl);
    endtask

    task automatic model_reset();
        exp_ctl = '0; exp_ret = '0; exp_be = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0; i_imemReady = rb(); i_memReady = rb();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        model_reset();
    endtask

    // Bus stuck: the error state ignores ready and needs a reset to leave.
    task automatic expect_error();
        exp_be = 1'b1;
        repeat (4) rnd_cycle(1'b1, 1'b1, 3'd5, 6'b000000);
        do_reset();
    endtask

    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3,
                             input int nf, input int nm, input logic rst_mem);
        logic br, ld, st, nop;
        br = (opc == 7'b1100011); ld = (opc == 7'b0000011);
        st = (opc == 7'b0100011); nop = !is_known(opc);
        for (int i = 0; i < nf && i < WAIT_LIMIT; i++) rnd_cycle(1'b0, rb(), 3'd0, 6'b100000);
        if (nf >= WAIT_LIMIT) begin expect_error(); return; end
        rnd_cycle(1'b1, rb(), 3'd0, 6'b110000);
        run_cycle(rb(), rb(), opc, f3, 3'd1, 6'b000000);
        exp_ctl = ref_ctl(opc, f3);
`ifdef ILLEGAL_TRAP_EN
        if (nop) begin
            repeat (3) rnd_cycle(rb(), rb(), 3'd6, 6'b000000);
            do_reset();
            return;
        end
`endif
        rnd_cycle(rb(), rb(), 3'd2, (br || nop) ? 6'b000001 : 6'b000000);
        if (br || nop) return;
        if (ld || st) begin
            for (int i = 0; i < nm && i < WAIT_LIMIT; i++) begin
                if (rst_mem) i_rst_n = 1'b0;
                rnd_cycle(rb(), 1'b0, 3'd3, {2'b00, 1'b1, st, 2'b00});
                if (rst_mem) begin i_rst_n = 1'b1; model_reset(); return; end
            end
            if (nm >= WAIT_LIMIT) begin expect_error(); return; end
            rnd_cycle(rb(), 1'b1, 3'd3, {2'b00, 1'b1, st, 1'b0, st});
            if (st) return;
        end
        rnd_cycle(rb(), rb(), 3'd4, 6'b000011);
    endtask

    logic [6:0] opc_tab [0:10];

    initial begin
        opc_tab = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                    7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0001011};
        i_rst_n = 1'b0; i_opcode = '0; i_funct3 = '0; i_imemReady = 1'b1; i_memReady = 1'b1;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        run_instr(7'b0000011, 3'b000, 0, 0, 1'b0);   // load, zero-wait
        run_instr(7'b1100011, 3'b001, 0, 0, 1'b0);   // branch retires in EXEC
        run_instr(7'b0100011, 3'b010, 0, 5, 1'b0);   // store, 5 wait cycles
        run_instr(7'b0000011, 3'b100, 2, 3, 1'b0);   // unsigned load
        run_instr(7'b0000011, 3'b000, 0, 3, 1'b1);   // reset mid-MEM
        run_instr(7'b1111111, 3'b000, 0, 0, 1'b0);   // unknown opcode
        run_instr(7'b0110011, 3'b000, 14, 0, 1'b0);  // ready just before limit
        run_instr(7'b0100011, 3'b000, 0, 14, 1'b0);
        run_instr(7'b0110111, 3'b000, 15, 0, 1'b0);  // fetch timeout
        run_instr(7'b0010111, 3'b000, 0, 0, 1'b0);
        run_instr(7'b0100011, 3'b000, 1, 15, 1'b0);  // data timeout

        for (int n = 0; n < 300; n++) begin
            int k, nf, nm;
            k  = $urandom_range(0, 10);
            nf = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 15) : $urandom_range(0, 3);
            nm = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 15) : $urandom_range(0, 3);
            run_instr(opc_tab[k], 3'($urandom), nf, nm, ($urandom_range(0, 29) == 0) && (nm > 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Successor to the single-cycle main decoder: the same RV32I opcode/funct3 decode, sequenced by a multi-cycle FSM (FETCH/DECODE/EXEC/MEM/WB).
- Waits on instruction- and data-memory ready handshakes, with a bus timeout and a retired-instruction counter.
- Sits between the instruction register and the datapath of the multi-cycle core.

Parameters:
WAIT_LIMIT, 15, max wait cycles on a memory handshake before bus error; 0 disables the timeout
RET_W, 32, width of retired-instruction counter

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_opcode  in  7  instruction opcode; valid when state is DECODE
i_funct3  in  3  instruction funct3; valid when state is DECODE
i_imemReady  in  1  instruction fetch ack
i_memReady  in  1  data memory ack
o_imemReq  out  1  instruction fetch request
o_irWrite  out  1  load instruction register (1-cycle pulse)
o_pcWrite  out  1  commit next PC (1-cycle pulse at retire)
o_memReq, o_memWrite  out  1 each  data memory request / write
o_regWrite  out  1  register file write (1-cycle pulse)
o_ALUSrc  out  1  ALU B operand: 0 = register, 1 = immediate
o_immSrc  out  3  immediate select: I=000 S=001 B=010 U=011 J=100
o_immPlusSrc  out  1  LUI=0 / AUIPC=1 immediate-plus select
o_isLoadSigned  out  1  funct3[2]==0 for loads
o_resultSrc  out  2  write-back select: 00 ALU, 01 mem, 10 PC+4, 11 imm-plus
o_branch, o_jal, o_jalr  out  1 each  PC source flags
o_ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded
o_state  out  3  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 ERROR=5 TRAP=6
o_busError  out  1  sticky timeout flag
o_retired  out  RET_W  retired-instruction count

Behaviour:
- Reset (i_rst_n low at a rising edge), including mid-instruction or mid-handshake:
  - State goes to FETCH.
  - All decoded controls, o_busError, wait counter and o_retired go to 0.
  - o_imemReq is 1 in the first cycle after reset, since the state is FETCH.
- Decode table, latched at the end of DECODE and held until the next DECODE:
  - load (0000011): ALUOp 00, ALUSrc 1, immSrc 000, resultSrc 01.
  - store (0100011): ALUOp 00, ALUSrc 1, immSrc 001.
  - R (0110011): ALUOp 10, ALUSrc 0, resultSrc 00.
  - I-ALU (0010011): ALUOp 10, ALUSrc 1, immSrc 000, resultSrc 00.
  - branch (1100011): ALUOp 01, ALUSrc 0, immSrc 010, branch 1.
  - jal (1101111): immSrc 100, resultSrc 10, jal 1.
  - jalr (1100111): ALUSrc 1, immSrc 000, resultSrc 10, jalr 1.
  - LUI (0110111) / AUIPC (0010111): immSrc 011, resultSrc 11, immPlusSrc 0 / 1.
  - Any field not listed for an opcode is 0.
- FETCH:
  - o_imemReq=1 until the first cycle in which i_imemReady=1.
  - In that cycle: o_irWrite=1 for one cycle, then go to DECODE.
- DECODE: exactly one cycle, then EXEC.
  - Unknown opcode without ILLEGAL_TRAP_EN: treated as NOP. o_pcWrite=1 and o_retired increments in the following EXEC cycle, then FETCH.
- EXEC: one cycle.
  - branch: retire here (o_pcWrite=1), then FETCH.
  - load/store: go to MEM.
  - all others: go to WB.
- MEM:
  - o_memReq=1 held until i_memReady=1; o_memWrite=1 throughout for stores.
  - Store: on ready, retire (o_pcWrite=1), then FETCH.
  - Load: on ready, go to WB.
- WB: o_regWrite=1 and o_pcWrite=1 for one cycle, then FETCH.
- Fetch-to-retire latency with zero-wait memories (ready already high):
  - branch: 3 cycles.
  - R/I/U/jal/jalr: 4 cycles.
  - store: 4 cycles.
  - load: 5 cycles.
- Ready outside FETCH/MEM: i_imemReady and i_memReady are ignored in every other state.
- Wait counter:
  - Increments each FETCH/MEM cycle in which ready=0.
  - Clears on ready and on any state change.
  - If WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT with ready still 0: go to ERROR and set o_busError=1.
  - A ready arriving in the same cycle the limit is reached takes priority (no error).
- ERROR:
  - All request/write/pulse outputs are 0.
  - Left only by reset.
- Retire:
  - Every o_pcWrite pulse increments o_retired by 1.
  - o_retired wraps modulo 2^RET_W.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- When defined: an unknown opcode in DECODE goes to TRAP instead of EXEC.
  - TRAP: all control outputs 0, o_pcWrite=0, no retire.
  - TRAP is held until reset; o_state reads 6.
- When undefined:
  - Unknown opcodes retire as NOP.
  - State 6 is unreachable.

Test Plan:
- Reset then load (0000011, f3 000), both readies tied 1:
  - Required states: 0,1,2,3,4.
  - Latched controls in EXEC: ALUOp 00, ALUSrc 1, immSrc 000, resultSrc 01, isLoadSigned 1.
  - o_memReq=1 in MEM; o_regWrite and o_pcWrite pulse in WB.
  - o_retired 0->1.
- Branch (1100011), readies 1: o_pcWrite in EXEC on cycle 3 after fetch start; o_regWrite and o_memReq never 1.
- Store with i_memReady low 5 cycles (WAIT_LIMIT=15):
  - o_memReq and o_memWrite held high for 6 cycles.
  - Retire on the 6th cycle; o_busError stays 0.
- i_imemReady held 0 with WAIT_LIMIT=15:
  - o_busError=1 and o_state=5 after exactly 15 FETCH wait cycles.
  - Raising i_imemReady afterwards has no effect; i_rst_n=0 for one edge returns to FETCH with o_busError=0.
- Reset asserted in MEM mid-handshake: next cycle o_state=0, o_memReq=0, o_imemReq=1, o_retired=0.
- Opcode 1111111:
  - With ILLEGAL_TRAP_EN: o_state=6 held, o_retired unchanged.
  - Without it: NOP retire, o_retired +1, back to FETCH.
